// File: rtl/score_keeper.sv
// Match scorer: saturating per-player score counters, IDLE/PLAY/OVER match FSM, serve and winner tracking.
// Optional win-by-two rule enabled by defining SCORE_KEEPER_WIN_BY_TWO_EN.
module score_keeper #(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned SCORE_WIDTH = 4,
  parameter int unsigned WIN_SCORE   = 11,
  localparam int unsigned IDX_W = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                               clock,
  input  logic                               reset,
  input  logic                               start,
  input  logic [NUM_PLAYERS-1:0]             point,
  output logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores,
  output logic                               playing,
  output logic                               game_over,
  output logic [IDX_W-1:0]                   winner,
  output logic [IDX_W-1:0]                   serve,
  output logic                               score_changed,
  output logic                               point_error
);

  localparam int unsigned SW1 = SCORE_WIDTH + 1;
  localparam logic [SCORE_WIDTH-1:0] SCORE_MAX = '1;

  typedef enum logic [1:0] {IDLE, PLAY, OVER} state_t;

  state_t                           state, state_d;
  logic [NUM_PLAYERS*SCORE_WIDTH-1:0] scores_d;
  logic [IDX_W-1:0]                 winner_d, serve_d;
  logic                             changed_d, error_d;
  logic [IDX_W-1:0]                 idx;
  logic [SCORE_WIDTH-1:0]           cur, nxt;
  logic                             win;

  // Scoring player, its saturated next score and whether that point wins
  always_comb begin
    idx = '0;
    cur = '0;
    for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
      if (point[i]) begin
        idx = IDX_W'(i);
        cur = scores[i*SCORE_WIDTH +: SCORE_WIDTH];
      end
    end
    nxt = (cur == SCORE_MAX) ? cur : cur + SCORE_WIDTH'(1);
    win = 32'(nxt) >= WIN_SCORE;
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    for (int unsigned j = 0; j < NUM_PLAYERS; j++) begin
      if (!point[j] &&
          (SW1'(nxt) < SW1'(scores[j*SCORE_WIDTH +: SCORE_WIDTH]) + SW1'(2)))
        win = 1'b0;
    end
`endif
  end

  // Next-state and next-output logic
  always_comb begin
    state_d   = state;
    scores_d  = scores;
    winner_d  = winner;
    serve_d   = serve;
    changed_d = 1'b0;
    error_d   = 1'b0;
    if (start) begin
      state_d   = PLAY;
      scores_d  = '0;
      winner_d  = '0;
      serve_d   = '0;
      changed_d = 1'b1;
    end else if (state == PLAY && point != '0) begin
      if ($onehot(point)) begin
        for (int unsigned i = 0; i < NUM_PLAYERS; i++) begin
          if (point[i]) scores_d[i*SCORE_WIDTH +: SCORE_WIDTH] = nxt;
        end
        serve_d   = idx;
        changed_d = 1'b1;
        if (win) begin
          winner_d = idx;
          state_d  = OVER;
        end
      end else begin
        error_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      scores        <= '0;
      winner        <= '0;
      serve         <= '0;
      playing       <= 1'b0;
      game_over     <= 1'b0;
      score_changed <= 1'b0;
      point_error   <= 1'b0;
    end else begin
      state         <= state_d;
      scores        <= scores_d;
      winner        <= winner_d;
      serve         <= serve_d;
      playing       <= (state_d == PLAY);
      game_over     <= (state_d == OVER);
      score_changed <= changed_d;
      point_error   <= error_d;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Self-checking bench for score_keeper: default 2-player instance plus a 4-player, 3-bit, win-at-7 instance.
// Honours SCORE_KEEPER_WIN_BY_TWO_EN in its reference model.
module tb_score_keeper;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start0 = 1'b0, start1 = 1'b0;
  logic [1:0]  point0 = '0;
  logic [3:0]  point1 = '0;
  logic [7:0]  scores0;
  logic [11:0] scores1;
  logic        playing0, playing1, over0, over1;
  logic        winner0, serve0;
  logic [1:0]  winner1, serve1;
  logic        chg0, chg1, err0, err1;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  score_keeper dut0 (
    .clock(clock), .reset(reset), .start(start0), .point(point0),
    .scores(scores0), .playing(playing0), .game_over(over0),
    .winner(winner0), .serve(serve0), .score_changed(chg0), .point_error(err0)
  );

  score_keeper #(.NUM_PLAYERS(4), .SCORE_WIDTH(3), .WIN_SCORE(7)) dut1 (
    .clock(clock), .reset(reset), .start(start1), .point(point1),
    .scores(scores1), .playing(playing1), .game_over(over1),
    .winner(winner1), .serve(serve1), .score_changed(chg1), .point_error(err1)
  );

  // Reference model: state 0=idle 1=play 2=over, scores as plain integers
  int m_state[2];
  int m_score[2][8];
  int m_serve[2];
  int m_winner[2];
  int m_chg[2];
  int m_err[2];

  function automatic int np(int k);   return (k == 0) ? 2 : 4;  endfunction
  function automatic int maxv(int k); return (k == 0) ? 15 : 7; endfunction
  function automatic int wins(int k); return (k == 0) ? 11 : 7; endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_state[k] = 0; m_serve[k] = 0; m_winner[k] = 0; m_chg[k] = 0; m_err[k] = 0;
      for (int i = 0; i < 8; i++) m_score[k][i] = 0;
    end
  endtask

  task automatic model_step(input int k, input bit st, input int pt);
    int cnt, who, nv;
    bit win;
    m_chg[k] = 0;
    m_err[k] = 0;
    if (st) begin
      for (int i = 0; i < 8; i++) m_score[k][i] = 0;
      m_serve[k] = 0; m_winner[k] = 0; m_state[k] = 1; m_chg[k] = 1;
    end else if (m_state[k] == 1 && pt != 0) begin
      cnt = 0; who = 0;
      for (int i = 0; i < np(k); i++)
        if (((pt >> i) & 1) == 1) begin cnt++; who = i; end
      if (cnt > 1) m_err[k] = 1;
      else begin
        nv = m_score[k][who] + 1;
        if (nv > maxv(k)) nv = maxv(k);
        m_score[k][who] = nv;
        m_serve[k] = who;
        m_chg[k] = 1;
        win = (nv >= wins(k));
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
        for (int j = 0; j < np(k); j++)
          if (j != who && nv < m_score[k][j] + 2) win = 0;
`endif
        if (win) begin m_winner[k] = who; m_state[k] = 2; end
      end
    end
  endtask

  task automatic cmp(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", name, got, exp, $time);
    end
  endtask

  function automatic int get_score(int k, int i);
    if (k == 0) return int'((scores0 >> (i * 4)) & 8'h0F);
    return int'((scores1 >> (i * 3)) & 12'h007);
  endfunction

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < np(k); i++)
        cmp($sformatf("dut%0d.score%0d", k, i), get_score(k, i), m_score[k][i]);
      cmp($sformatf("dut%0d.playing", k), (k == 0) ? int'(playing0) : int'(playing1), int'(m_state[k] == 1));
      cmp($sformatf("dut%0d.game_over", k), (k == 0) ? int'(over0) : int'(over1), int'(m_state[k] == 2));
      cmp($sformatf("dut%0d.winner", k), (k == 0) ? int'(winner0) : int'(winner1), m_winner[k]);
      cmp($sformatf("dut%0d.serve", k), (k == 0) ? int'(serve0) : int'(serve1), m_serve[k]);
      cmp($sformatf("dut%0d.score_changed", k), (k == 0) ? int'(chg0) : int'(chg1), m_chg[k]);
      cmp($sformatf("dut%0d.point_error", k), (k == 0) ? int'(err0) : int'(err1), m_err[k]);
    end
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model
  task automatic cyc(input bit s0, input logic [1:0] p0, input bit s1, input logic [3:0] p1);
    start0 = s0; point0 = p0; start1 = s1; point1 = p1;
    @(posedge clock);
    #1;
    model_step(0, s0, int'(p0));
    model_step(1, s1, int'(p1));
    start0 = 1'b0; point0 = '0; start1 = 1'b0; point1 = '0;
  endtask

  typedef struct {
    bit         start;
    logic [1:0] point;
    int s0, s1, playing, over, winner, serve, chg, err;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 2'b01, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[1] = '{1'b0, 2'b11, 0, 0, 0, 0, 0, 0, 0, 0};
    tbl[2] = '{1'b1, 2'b00, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[3] = '{1'b0, 2'b01, 1, 0, 1, 0, 0, 0, 1, 0};
    tbl[4] = '{1'b0, 2'b10, 1, 1, 1, 0, 0, 1, 1, 0};
    tbl[5] = '{1'b0, 2'b11, 1, 1, 1, 0, 0, 1, 0, 1};
    tbl[6] = '{1'b0, 2'b00, 1, 1, 1, 0, 0, 1, 0, 0};
    tbl[7] = '{1'b1, 2'b10, 0, 0, 1, 0, 0, 0, 1, 0};
    tbl[8] = '{1'b0, 2'b10, 0, 1, 1, 0, 0, 1, 1, 0};
    tbl[9] = '{1'b0, 2'b01, 1, 1, 1, 0, 0, 0, 1, 0};

    model_reset();
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    check_all();

    // Table vectors on the 2-player instance
    for (int v = 0; v < 10; v++) begin
      cyc(tbl[v].start, tbl[v].point, 1'b0, 4'b0000);
      cmp($sformatf("tbl%0d.score0", v), get_score(0, 0), tbl[v].s0);
      cmp($sformatf("tbl%0d.score1", v), get_score(0, 1), tbl[v].s1);
      cmp($sformatf("tbl%0d.playing", v), int'(playing0), tbl[v].playing);
      cmp($sformatf("tbl%0d.game_over", v), int'(over0), tbl[v].over);
      cmp($sformatf("tbl%0d.winner", v), int'(winner0), tbl[v].winner);
      cmp($sformatf("tbl%0d.serve", v), int'(serve0), tbl[v].serve);
      cmp($sformatf("tbl%0d.score_changed", v), int'(chg0), tbl[v].chg);
      cmp($sformatf("tbl%0d.point_error", v), int'(err0), tbl[v].err);
    end

    // Eleven straight points for P0, then further strobes are ignored
    cyc(1'b1, 2'b00, 1'b0, 4'b0000);
    for (int n = 0; n < 11; n++) begin
      cyc(1'b0, 2'b01, 1'b0, 4'b0000);
      check_all();
    end
    cmp("p0run.score0", get_score(0, 0), 11);
    cmp("p0run.game_over", int'(over0), 1);
    cmp("p0run.playing", int'(playing0), 0);
    cmp("p0run.winner", int'(winner0), 0);
    cyc(1'b0, 2'b01, 1'b0, 4'b0000);
    cyc(1'b0, 2'b10, 1'b0, 4'b0000);
    cmp("p0run.frozen0", get_score(0, 0), 11);
    cmp("p0run.frozen1", get_score(0, 1), 0);
    cmp("p0run.frozen_chg", int'(chg0), 0);

    // Deuce: reach 10-10, then P0, P1, P0, P0
    cyc(1'b1, 2'b00, 1'b0, 4'b0000);
    for (int n = 0; n < 10; n++) begin
      cyc(1'b0, 2'b01, 1'b0, 4'b0000);
      cyc(1'b0, 2'b10, 1'b0, 4'b0000);
    end
    check_all();
    cyc(1'b0, 2'b01, 1'b0, 4'b0000); check_all();
    cyc(1'b0, 2'b10, 1'b0, 4'b0000); check_all();
    cyc(1'b0, 2'b01, 1'b0, 4'b0000); check_all();
    cyc(1'b0, 2'b01, 1'b0, 4'b0000); check_all();
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    cmp("deuce.score0", get_score(0, 0), 13);
    cmp("deuce.score1", get_score(0, 1), 11);
`else
    cmp("deuce.score0", get_score(0, 0), 11);
    cmp("deuce.score1", get_score(0, 1), 10);
`endif
    cmp("deuce.game_over", int'(over0), 1);
    cmp("deuce.winner", int'(winner0), 0);

    // Async reset mid-match at 5-3
    cyc(1'b1, 2'b00, 1'b0, 4'b0000);
    for (int n = 0; n < 5; n++) cyc(1'b0, 2'b01, 1'b0, 4'b0000);
    for (int n = 0; n < 3; n++) cyc(1'b0, 2'b10, 1'b0, 4'b0000);
    cmp("prereset.score0", get_score(0, 0), 5);
    cmp("prereset.score1", get_score(0, 1), 3);
    #3 reset = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clock);
    #1 reset = 1'b0;
    cyc(1'b0, 2'b01, 1'b0, 4'b0100); check_all();
    cyc(1'b0, 2'b11, 1'b0, 4'b1000); check_all();

    // 4-player instance: P2 and P3 alternate towards saturation
    cyc(1'b0, 2'b00, 1'b1, 4'b0000);
    for (int n = 0; n < 9; n++) begin
      cyc(1'b0, 2'b00, 1'b0, 4'b0100);
      check_all();
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
      cmp("sat.chg_p2", int'(chg1), 1);
`endif
      cyc(1'b0, 2'b00, 1'b0, 4'b1000);
      check_all();
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
      cmp("sat.chg_p3", int'(chg1), 1);
`endif
    end
`ifdef SCORE_KEEPER_WIN_BY_TWO_EN
    cmp("sat.score2", get_score(1, 2), 7);
    cmp("sat.score3", get_score(1, 3), 7);
    cmp("sat.game_over", int'(over1), 0);
    cmp("sat.playing", int'(playing1), 1);
`else
    cmp("sat.score2", get_score(1, 2), 7);
    cmp("sat.score3", get_score(1, 3), 6);
    cmp("sat.game_over", int'(over1), 1);
    cmp("sat.winner", int'(winner1), 2);
`endif

    // Random traffic on both instances against the model
    for (int n = 0; n < 600; n++) begin
      bit s0, s1;
      logic [1:0] p0;
      logic [3:0] p1;
      s0 = ($urandom_range(0, 39) == 0);
      s1 = ($urandom_range(0, 39) == 0);
      p0 = 2'($urandom_range(0, 3));
      p1 = ($urandom_range(0, 3) != 0) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
      cyc(s0, p0, s1, p1);
      check_all();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
